// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, encodings and the fetch-queue entry type.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with clear; head reads 0 when empty.
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic [CW-1:0] cnt;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && cnt != '0;
    assign do_push = push && (cnt != CW'(DEPTH) || do_pop);
    assign dout    = cnt != '0 ? mem[rd] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else if (clr) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wr <= nxt(wr);
            if (do_pop) rd <= nxt(rd);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr] <= din;
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch with credit-limited requests,
// PC tagging of responses and flush that discards in-flight work.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int XLEN  = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_hold,
    input  logic            flush,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc
);
    import riscv_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]   inflight, drop, count;
    logic            accept, rsp_ok, q_push, q_pop;
    logic [XLEN-1:0] tag_head;
    if_entry_t       q_in, q_head;

    // Queue slots plus outstanding requests never exceed DEPTH, so a response always has room.
    assign imem_req_valid = !rst && !flush && ({1'b0, inflight} + {1'b0, count} < (CW + 1)'(DEPTH));
    assign accept         = imem_req_valid && imem_req_ready;
    assign pc_hold        = !accept;
    assign imem_addr      = pc_in;
    assign rsp_ok         = imem_rsp_valid && inflight != '0;
    assign q_push         = rsp_ok && drop == '0 && !flush;
    assign id_valid       = count != '0;
    assign q_pop          = id_valid && id_ready && !flush;
    assign q_in           = '{pc: tag_head, instr: imem_rsp_data};
    assign id_pc          = q_head.pc;
    assign id_instr       = q_head.instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
            drop     <= '0;
            count    <= '0;
        end else begin
            inflight <= inflight + CW'(accept) - CW'(rsp_ok);
            drop     <= flush ? inflight - CW'(rsp_ok) : drop - CW'(rsp_ok && drop != '0);
            count    <= flush ? '0 : count + CW'(q_push) - CW'(q_pop);
        end
    end

    fetch_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_tag (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .push (accept),
        .din  (pc_in),
        .pop  (rsp_ok),
        .dout (tag_head)
    );

    fetch_fifo #(.W($bits(if_entry_t)), .DEPTH(DEPTH)) u_queue (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .push (q_push),
        .din  (q_in),
        .pop  (q_pop),
        .dout (q_head)
    );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized fetch traffic against an epoch-based reference
// model; a separate monitor scores the decode-side output stream.
module tb_fetch_queue;
    localparam int DEPTH = 2;

    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] pc_in = 0;
    logic        pc_hold;
    logic        flush = 0;
    logic        imem_req_valid;
    logic        imem_req_ready = 0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 0;
    logic [31:0] imem_rsp_data = 0;
    logic        id_valid;
    logic        id_ready = 0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_hold        (pc_hold),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          due;
        int          ep;
    } req_t;

    req_t        pending[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0, n_err = 0, n_pops = 0;
    int          cyc = 0, epoch = 0;
    logic [31:0] pc_reg = 0, flush_tgt = 32'h40;
    int          lat_min = 1, lat_max = 1, rdy_mode = 0, idr_mode = 0, flush_pct = 0;
    bit          flush_two = 0, flush_rsp = 0, stray = 0, rnd_tgt = 0;
    int          mon_mc;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return (pc * 32'h9E3779B1) ^ 32'h00000013;
    endfunction

    function automatic int cur_inflight();
        int n = 0;
        foreach (pending[i]) if (pending[i].ep == epoch) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Decode-side monitor: the head must be the oldest accepted PC of the current epoch.
    initial forever begin
        @(negedge clk);
        #1;
        if (!rst) begin
            mon_mc = exp_q.size() - cur_inflight();
            chk("id_valid", {31'b0, id_valid}, {31'b0, mon_mc != 0});
            chk("no_overflow", {31'b0, int'(dut.count) <= DEPTH}, 32'd1);
            if (mon_mc != 0) begin
                chk("id_pc", id_pc, exp_q[0]);
                chk("id_instr", id_instr, word_of(exp_q[0]));
                if (id_ready && !flush) begin
                    void'(exp_q.pop_front());
                    n_pops++;
                end
            end else begin
                chk("id_pc_idle", id_pc, 32'd0);
                chk("id_instr_idle", id_instr, 32'd0);
            end
        end
    end

    task automatic step();
        int  ci, oi, mc, due;
        bit  hit, ev;
        @(negedge clk);
        cyc++;
        imem_req_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? cyc[0] :
                         rdy_mode == 2 ? 1'($urandom_range(1)) : 1'b0;
        id_ready = idr_mode == 0 ? 1'b1 : idr_mode == 1 ? 1'b0 : 1'($urandom_range(1));
        hit = pending.size() > 0 && pending[0].due <= cyc;
        imem_rsp_valid = hit || stray;
        imem_rsp_data = hit ? word_of(pending[0].pc) : $urandom();
        stray = 0;
        ci = cur_inflight();
        oi = pending.size() - ci;
        mc = exp_q.size() - ci;
        flush = (int'($urandom_range(99)) < flush_pct) || (flush_two && ci == 2) ||
                (flush_rsp && hit && mc > 0 && id_ready);
        if (flush) begin
            flush_two = 0;
            flush_rsp = 0;
        end
        pc_in = pc_reg;
        #2;
        ev = !flush && (pending.size() + mc < DEPTH);
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, ev});
        chk("pc_hold", {31'b0, pc_hold}, {31'b0, !(ev && imem_req_ready)});
        chk("imem_addr", imem_addr, pc_in);
        chk("drop", {30'b0, dut.drop}, oi);
        if (hit) void'(pending.pop_front());
        if (flush) begin
            exp_q.delete();
            epoch++;
            pc_reg = flush_tgt;
            if (rnd_tgt) flush_tgt = {20'b0, 10'($urandom_range(1023)), 2'b00};
        end else if (ev && imem_req_ready) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (pending.size() > 0 && pending[$].due >= due) due = pending[$].due + 1;
            pending.push_back('{pc_in, due, epoch});
            exp_q.push_back(pc_in);
            pc_reg += 4;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        flush = 0;
        imem_req_ready = 0;
        imem_rsp_valid = 0;
        id_ready = 0;
        pending.delete();
        exp_q.delete();
        pc_reg = 0;
        pc_in = 0;
        #1;
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_instr", id_instr, 32'd0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_pc_hold", {31'b0, pc_hold}, 32'd1);
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        int p0;
        do_reset();
        // Back-to-back fetch from 0 with 1-cycle memory.
        p0 = n_pops;
        repeat (20) step();
        chk("progress", {31'b0, (n_pops - p0) >= 8}, 32'd1);
        // Decode stalls, then drains.
        idr_mode = 1;
        repeat (5) step();
        chk("stall_full", {30'b0, dut.count}, 32'd2);
        idr_mode = 0;
        repeat (10) step();
        // Memory ready toggling every cycle.
        rdy_mode = 1;
        repeat (20) step();
        // 3-cycle memory; redirect to 0x40 with two requests outstanding.
        rdy_mode = 0;
        lat_min = 3;
        lat_max = 3;
        flush_tgt = 32'h40;
        flush_two = 1;
        repeat (20) step();
        chk("flush_two_fired", {31'b0, flush_two}, 32'd0);
        // Flush coinciding with a response and a pop.
        lat_min = 1;
        lat_max = 1;
        flush_tgt = 32'h80;
        flush_rsp = 1;
        repeat (15) step();
        chk("flush_rsp_fired", {31'b0, flush_rsp}, 32'd0);
        // Random traffic with random latency, backpressure and redirects.
        lat_max = 4;
        rdy_mode = 2;
        idr_mode = 2;
        flush_pct = 5;
        rnd_tgt = 1;
        repeat (400) step();
        // Fill the queue, then reset mid-stream.
        flush_pct = 0;
        lat_max = 1;
        rdy_mode = 0;
        idr_mode = 1;
        for (int i = 0; i < 20 && (exp_q.size() - cur_inflight()) != 2; i++) step();
        chk("queue_filled", exp_q.size() - cur_inflight(), 32'd2);
        do_reset();
        // A response with nothing outstanding is ignored.
        rdy_mode = 3;
        stray = 1;
        repeat (4) step();
        chk("stray_inflight", {30'b0, dut.inflight}, 32'd0);
        // Fetch restarts from 0.
        rdy_mode = 0;
        idr_mode = 0;
        repeat (12) step();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
